// File: rtl/spi_master.sv
// SPI mode-0 initiator: one register read/write frame per start pulse.
// Frame = {we, address, data} MSB-first; sclk half-period is CLK_DIV clk cycles.
module spi_master #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned CLK_DIV = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);
  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t               state, state_n;
  logic [DIV_W-1:0]     div, div_n;
  logic [BIT_W-1:0]     bit_idx, bit_n;
  logic                 high, high_n;
  logic [FRAME_W-1:0]   shreg, shreg_n, frame;
  logic [DATA_W-1:0]    cap, cap_n, rdata_n;
  logic                 we_q, we_n;
  logic                 sclk_n, ss_n, mosi_n, busy_n, done_n;
  logic                 div_last, launch;

  always_comb begin
    frame    = {we, address, (we ? wdata : {DATA_W{1'b0}})};
    div_last = (div == DIV_W'(CLK_DIV - 1));
    state_n  = state;
    div_n    = div_last ? '0 : div + 1'b1;
    bit_n    = bit_idx;
    high_n   = high;
    shreg_n  = shreg;
    cap_n    = cap;
    we_n     = we_q;
    rdata_n  = rdata;
    sclk_n   = sclk;
    ss_n     = ss;
    mosi_n   = mosi;
    busy_n   = busy;
    done_n   = 1'b0;
    launch   = 1'b0;

    case (state)
      IDLE: begin
        div_n  = '0;
        ss_n   = 1'b1;
        sclk_n = 1'b0;
        mosi_n = 1'b0;
        busy_n = 1'b0;
        launch = start;
      end
      SETUP: begin
        if (div_last) begin
          state_n = SHIFT;
          sclk_n  = 1'b1;
          high_n  = 1'b1;
          bit_n   = '0;
          cap_n   = {cap[DATA_W-2:0], miso};
        end
      end
      SHIFT: begin
        if (div_last) begin
          if (high) begin
            sclk_n  = 1'b0;
            high_n  = 1'b0;
            shreg_n = {shreg[FRAME_W-2:0], 1'b0};
            mosi_n  = shreg[FRAME_W-2];
          end else if (bit_idx == BIT_W'(FRAME_W - 1)) begin
            state_n = HOLD;
            ss_n    = 1'b1;
            mosi_n  = 1'b0;
          end else begin
            bit_n  = bit_idx + 1'b1;
            sclk_n = 1'b1;
            high_n = 1'b1;
            cap_n  = {cap[DATA_W-2:0], miso};
          end
        end
      end
      HOLD: begin
        if (div_last) begin
          state_n = IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          if (!we_q) rdata_n = cap;
          // A held start relaunches here so the inter-frame gap is exactly HOLD.
          launch = start;
        end
      end
      default: state_n = IDLE;
    endcase

    if (launch) begin
      state_n = SETUP;
      div_n   = '0;
      shreg_n = frame;
      we_n    = we;
      ss_n    = 1'b0;
      busy_n  = 1'b1;
      mosi_n  = we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      bit_idx <= '0;
      high    <= 1'b0;
      shreg   <= '0;
      cap     <= '0;
      we_q    <= 1'b0;
      rdata   <= '0;
      sclk    <= 1'b0;
      ss      <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      bit_idx <= bit_n;
      high    <= high_n;
      shreg   <= shreg_n;
      cap     <= cap_n;
      we_q    <= we_n;
      rdata   <= rdata_n;
      sclk    <= sclk_n;
      ss      <= ss_n;
      mosi    <= mosi_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end
endmodule

// File: doc/spi_master.md
# spi_master

SPI bus initiator that runs single-register read/write transactions against the SPI slave register interface over `sclk`/`ss`/`mosi`/`miso`. It lets an on-chip controller or the loopback testbench reach a remote register bank. The block runs one transaction per `start` pulse, generates `sclk` by dividing `clk`, and returns read data with a one-cycle `done` pulse.

## Interface
- `DATA_W`, 32: register data width; must equal the slave's data width.
- `ADDR_W`, 5: register address width; must equal the slave's address width.
- `CLK_DIV`, 8: `clk` cycles per `sclk` half-period. Minimum legal value is 2.

Ports:
- `clk`  in  1  system clock, the only clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `start`  in  1  request a transaction; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; sampled with `start`.
- `address`  in  ADDR_W  target register; sampled with `start`.
- `wdata`  in  DATA_W  write data; sampled with `start`.
- `rdata`  out  DATA_W  read data; valid from the `done` cycle until the next read completes.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle completion pulse.
- `sclk`  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- `ss`  out  1  slave select, active-low.
- `mosi`  out  1  serial data to the slave.
- `miso`  in  1  serial data from the slave.

## Operation
- Frame format: FRAME_W = 1 + ADDR_W + DATA_W bits, sent MSB-first.
  - Bit order is `we` flag, then `address[ADDR_W-1:0]`, then data.
  - For a read, the data-phase `mosi` bits are 0.
- The master drives `mosi` while `sclk` is low. `mosi` changes only on falling `sclk` edges or in SETUP.
- The master samples `miso` on the `clk` edge that drives `sclk` from 0 to 1.
- Read: the last DATA_W sampled `miso` bits are shifted MSB-first into a capture register. That register is copied to `rdata` at `done`. `miso` is ignored during the flag and address bits.
- Write: `rdata` is not modified.
- State machine:
  - IDLE: `ss`=1, `sclk`=0, `busy`=0. On `start`=1, latch the frame into the shift register and go to SETUP.
  - SETUP: `ss`=0, `sclk`=0, `mosi` = frame bit FRAME_W-1. Lasts CLK_DIV cycles, then go to SHIFT.
  - SHIFT: a bit counter runs 0..FRAME_W-1. Each bit is a high half (CLK_DIV cycles) followed by a low half (CLK_DIV cycles). At the end of each high half, `sclk` falls and `mosi` advances to the next bit. After the low half of the last bit, go to HOLD.
  - HOLD: `ss`=1, `sclk`=0, `mosi`=0. Lasts CLK_DIV cycles, then go to IDLE.
- Leaving HOLD: `done`=1 for exactly one cycle, `busy` returns to 0 in that same cycle, and `rdata` is updated (reads only).
- `start` while `busy`=1 is ignored; requests are not queued.
- `start` held high in IDLE starts a new transaction each time IDLE is re-entered. The gap between transactions is exactly the HOLD time.
- Reset, asserted at any time including mid-frame:
  - Immediately forces `ss`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rdata`=0, state IDLE, and clears the counters.
  - No `done` is issued for an aborted frame.

## Timing
- `start` is accepted on clock edge E. On edge E+1, `busy`=1 and `ss`=0.
- `busy` stays high for exactly CLK_DIV·(2·FRAME_W + 2) cycles. With the defaults (FRAME_W=38) that is 624 cycles.
- The first rising `sclk` edge occurs CLK_DIV cycles after `ss` falls.
- `ss` rises CLK_DIV cycles after the last falling `sclk` edge.
- `done` and the new `rdata` appear on the same edge at which `busy` falls.
- Every `sclk` half-period is exactly CLK_DIV `clk` cycles, with no jitter.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
1. Write, defaults: `we`=1, `address`=5'h03, `wdata`=32'hDEADBEEF.
   - Bench decodes the `mosi` frame 1, 00011, DEADBEEF (38 bits).
   - Exactly 38 rising `sclk` edges.
   - `busy` high for 624 cycles, one `done` pulse, `rdata` unchanged.
2. Read: `we`=0, `address`=5'h1F, with the slave model returning 32'hA5A5_0F0F.
   - `mosi` decodes to 0, 11111, then 32 zeros.
   - `rdata`=32'hA5A50F0F at `done`.
3. Write to 5'h07 with 32'h12345678 through the real slave and register bank, then read 5'h07.
   - `rdata`=32'h12345678.
4. Pulse `start` again 10 cycles into a transaction.
   - Ignored: a single frame, a single `done`, `busy` length unchanged.
5. Assert `rst` at bit 20 of a read.
   - Same cycle: `ss`=1, `sclk`=0, `busy`=0, `rdata`=0.
   - No `done` pulse.
   - A read started after reset completes normally.
6. CLK_DIV=2, `start` held high across two transactions.
   - Every `sclk` half-period is 2 cycles.
   - `ss` is high for exactly 2 cycles between the frames.
   - Two `done` pulses, 156 cycles apart.
